// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-fetch stage in front of the 32-bit ALU.
// Holds a 32-entry register file with one write-back port and two read
// ports with write-through bypass. The selected operands and opcode are
// captured into a single valid/ready pipeline slot that the ALU can stall.
module alu_operand_stage #(
  parameter int WIDTH     = 32,
  parameter int NREG_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NREG_LOG2-1:0] rs,
  input  logic [NREG_LOG2-1:0] rt,
  input  logic [2:0]           op_in,
  input  logic                 use_imm,
  input  logic [WIDTH-1:0]     imm,
  input  logic                 we,
  input  logic [NREG_LOG2-1:0] wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic [2:0]           ALUOp
);

  localparam int NREG = 2 ** NREG_LOG2;

  logic [WIDTH-1:0] regs_r [NREG];
  logic             out_valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       aluop_r;

  logic             wr_en_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;
  logic [WIDTH-1:0] a_next_s;
  logic [WIDTH-1:0] b_next_s;
  logic             in_ready_s;
  logic             capture_s;

  // Register 0 is hard-wired to zero, so writes to it never take effect.
  assign wr_en_s = we && (wa != {NREG_LOG2{1'b0}});

  // Register file write-back; reset clears every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[wa] <= wd;
    end else begin
      regs_r[wa] <= regs_r[wa];
    end
  end

  // Port A read: a same-cycle write to rs is forwarded ahead of the array.
  always_comb begin
    rd_a_s = {WIDTH{1'b0}};
    if (wr_en_s && (wa == rs)) begin
      rd_a_s = wd;
    end else if (rs == {NREG_LOG2{1'b0}}) begin
      rd_a_s = {WIDTH{1'b0}};
    end else begin
      rd_a_s = regs_r[rs];
    end
  end

  // Port B read: same forwarding rule as port A, applied to rt.
  always_comb begin
    rd_b_s = {WIDTH{1'b0}};
    if (wr_en_s && (wa == rt)) begin
      rd_b_s = wd;
    end else if (rt == {NREG_LOG2{1'b0}}) begin
      rd_b_s = {WIDTH{1'b0}};
    end else begin
      rd_b_s = regs_r[rt];
    end
  end

  // Operand select: B takes the pre-extended immediate when requested.
  always_comb begin
    a_next_s = rd_a_s;
    b_next_s = {WIDTH{1'b0}};
    if (use_imm) begin
      b_next_s = imm;
    end else begin
      b_next_s = rd_b_s;
    end
  end

  // The slot can take a new entry when empty or when it drains this cycle.
  assign in_ready_s = !out_valid_r || out_ready;
  assign capture_s  = in_valid && in_ready_s && !flush;

  // Output slot: reset beats flush, flush beats capture, capture beats drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      aluop_r     <= 3'b000;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
      a_r         <= a_next_s;
      b_r         <= b_next_s;
      aluop_r     <= op_in;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign A         = a_r;
  assign B         = b_r;
  assign ALUOp     = aluop_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed scenarios plus random traffic,
// all checked against a behavioural model of the register file and slot.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [2:0]  op_in;
  logic        use_imm;
  logic [31:0] imm;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [2:0]  m_op;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .op_in(op_in), .use_imm(use_imm), .imm(imm),
    .we(we), .wa(wa), .wd(wd), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .A(A), .B(B), .ALUOp(ALUOp)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 1'b0; in_valid = 1'b0; rs = 5'd0; rt = 5'd0; op_in = 3'd0;
    use_imm = 1'b0; imm = 32'd0; we = 1'b0; wa = 5'd0; wd = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
  endtask

  // Reads see a same-cycle write except to register 0.
  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (we && wa != 5'd0 && wa == r) return wd;
    return m_regs[r];
  endfunction

  // Advance one clock and update the model from the inputs present before the edge.
  task automatic cycle();
    logic [31:0] na, nb;
    logic        cap;
    na  = model_read(rs);
    nb  = use_imm ? imm : model_read(rt);
    cap = in_valid && (!m_valid || out_ready) && !flush;
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_op = 3'd0;
    end else begin
      if (flush) m_valid = 1'b0;
      else if (cap) begin
        m_valid = 1'b1; m_a = na; m_b = nb; m_op = op_in;
      end else if (out_ready) m_valid = 1'b0;
      if (we && wa != 5'd0) m_regs[wa] = wd;
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    we = 1'b1; wa = 5'd3; wd = 32'hdeadbeef;
    cycle();
    cycle();
    idle();
    #1;
    vectors++;
    if ({out_valid, A, B, ALUOp} !== {1'b0, 32'd0, 32'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b A=%h B=%h op=%h, want all zero", out_valid, A, B, ALUOp);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    // write during reset must have been ignored
    in_valid = 1'b1; rs = 5'd3; rt = 5'd3; out_ready = 1'b1;
    cycle();
    vectors++;
    if (A !== 32'd0 || B !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_write_ignored: got A=%h B=%h want 0", A, B);
    end
  endtask

  task automatic test_basic();
    idle();
    we = 1'b1; wa = 5'd1; wd = 32'hf0001000;
    cycle();
    idle();
    in_valid = 1'b1; rs = 5'd1; use_imm = 1'b1; imm = 32'd1; op_in = 3'b101; out_ready = 1'b1;
    cycle();
    vectors++;
    if ({out_valid, A, B, ALUOp} !== {1'b1, 32'hf0001000, 32'd1, 3'b101}) begin
      miscompares++;
      $display("FAIL basic_capture: got v=%b A=%h B=%h op=%b want v=1 A=f0001000 B=1 op=101",
               out_valid, A, B, ALUOp);
    end
  endtask

  task automatic test_bypass();
    idle();
    out_ready = 1'b1;
    we = 1'b1; wa = 5'd2; wd = 32'h12345678;
    in_valid = 1'b1; rs = 5'd2; rt = 5'd2; use_imm = 1'b0; op_in = 3'b010;
    cycle();
    vectors++;
    if (A !== 32'h12345678 || B !== 32'h12345678 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass: got v=%b A=%h B=%h want v=1 A=B=12345678", out_valid, A, B);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    out_ready = 1'b1;
    we = 1'b1; wa = 5'd0; wd = 32'hffffffff;
    in_valid = 1'b1; rs = 5'd0; rt = 5'd0; use_imm = 1'b0; op_in = 3'b011;
    cycle();
    vectors++;
    if (A !== 32'd0 || B !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_reg_bypass: got A=%h B=%h want 0", A, B);
    end
    we = 1'b0;
    cycle();
    vectors++;
    if (A !== 32'd0 || B !== 32'd0) begin
      miscompares++;
      $display("FAIL zero_reg_later: got A=%h B=%h want 0", A, B);
    end
  endtask

  task automatic test_stall();
    idle();
    we = 1'b1; wa = 5'd1; wd = 32'hf0001000;
    cycle();
    idle();
    in_valid = 1'b1; rs = 5'd1; use_imm = 1'b1; imm = 32'd7; op_in = 3'b101; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0; rs = 5'd2;
    we = 1'b1; wa = 5'd1; wd = 32'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      cycle();
      vectors++;
      if (out_valid !== 1'b1 || A !== 32'hf0001000 || B !== 32'd7) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%b A=%h B=%h want v=1 A=f0001000 B=7", i, out_valid, A, B);
      end
    end
    we = 1'b0; out_ready = 1'b1; rs = 5'd1; imm = 32'd9; op_in = 3'b001;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    cycle();
    vectors++;
    if ({out_valid, A, B, ALUOp} !== {1'b1, 32'h5, 32'd9, 3'b001}) begin
      miscompares++;
      $display("FAIL stall_release_capture: got v=%b A=%h B=%h op=%b want v=1 A=5 B=9 op=001",
               out_valid, A, B, ALUOp);
    end
  endtask

  task automatic test_flush();
    // slot is valid from the previous scenario
    idle();
    flush = 1'b1; in_valid = 1'b1; rs = 5'd1; out_ready = 1'b0;
    we = 1'b1; wa = 5'd4; wd = 32'habcd0004;
    #1;
    vectors++;
    if (in_ready !== (!m_valid || out_ready)) begin
      miscompares++;
      $display("FAIL flush_in_ready: got %b want %b", in_ready, !m_valid || out_ready);
    end
    cycle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_valid: got %b want 0", out_valid);
    end
    idle();
    in_valid = 1'b1; rs = 5'd4; rt = 5'd4; out_ready = 1'b1;
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || A !== 32'habcd0004 || B !== 32'habcd0004) begin
      miscompares++;
      $display("FAIL flush_write_kept: got v=%b A=%h B=%h want v=1 A=B=abcd0004", out_valid, A, B);
    end
  endtask

  task automatic test_mid_reset();
    idle();
    in_valid = 1'b1; rs = 5'd1; rt = 5'd4; op_in = 3'b110; out_ready = 1'b1;
    cycle();
    idle();
    cycle();
    reset = 1'b1; in_valid = 1'b1; rs = 5'd1;
    cycle();
    vectors++;
    if ({out_valid, A, B, ALUOp} !== {1'b0, 32'd0, 32'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL mid_reset_slot: got v=%b A=%h B=%h op=%b want all zero", out_valid, A, B, ALUOp);
    end
    idle();
    in_valid = 1'b1; rs = 5'd1; rt = 5'd1; out_ready = 1'b1;
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || A !== 32'd0 || B !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_regs: got v=%b A=%h B=%h want v=1 A=B=0", out_valid, A, B);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    out_ready = 1'b1; in_valid = 1'b1; use_imm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imm = 32'h100 + i; op_in = i[2:0]; we = 1'b1; wa = 5'd8 + i[4:0]; wd = 32'h5000 + i;
      rs = wa;
      cycle();
      vectors++;
      if (out_valid !== 1'b1 || A !== 32'h5000 + i || B !== 32'h100 + i || ALUOp !== i[2:0]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got v=%b A=%h B=%h op=%b", i, out_valid, A, B, ALUOp);
      end
    end
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(63) == 0);
      flush    = ($urandom_range(15) == 0);
      in_valid = $urandom_range(1);
      out_ready = ($urandom_range(3) != 0);
      we       = $urandom_range(1);
      wa       = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      wd       = $urandom;
      rs       = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
      rt       = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
      use_imm  = $urandom_range(1);
      imm      = $urandom;
      op_in    = 3'($urandom_range(7));
      #1;
      vectors++;
      if (in_ready !== (!m_valid || out_ready)) begin
        miscompares++;
        $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, !m_valid || out_ready);
      end
      cycle();
      vectors++;
      if (out_valid !== m_valid ||
          (m_valid && (A !== m_a || B !== m_b || ALUOp !== m_op))) begin
        miscompares++;
        $display("FAIL rand_slot[%0d]: got v=%b A=%h B=%h op=%b want v=%b A=%h B=%h op=%b",
                 i, out_valid, A, B, ALUOp, m_valid, m_a, m_b, m_op);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_op = 3'd0;
    idle();
    #2;
    test_reset();
    test_basic();
    test_bypass();
    test_zero_reg();
    test_stall();
    test_flush();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage that sits directly upstream of the 32-bit ALU (inputs A, B, ALUOp[2:0]).
- Contains a 32 x 32-bit general register file with a write-back port.
- Reads two source registers, or one register plus an immediate, and registers the chosen operands together with the ALU opcode into one output pipeline slot.
- The slot uses a valid/ready handshake, so the ALU side can stall the stage.

Parameters:
- WIDTH, 32, datapath width of registers, operands and immediate.
- NREG_LOG2, 5, register address width (2^5 = 32 registers).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction present on rs/rt/op_in/use_imm/imm.
- in_ready  output  1  stage accepts the instruction this cycle.
- rs  input  NREG_LOG2  source register for operand A.
- rt  input  NREG_LOG2  source register for operand B.
- op_in  input  3  ALU opcode forwarded unchanged.
- use_imm  input  1  1: B comes from imm; 0: B comes from reg[rt].
- imm  input  WIDTH  already-extended immediate.
- we  input  1  write-back enable.
- wa  input  NREG_LOG2  write-back address.
- wd  input  WIDTH  write-back data.
- flush  input  1  discard the slot contents.
- out_valid  output  1  A/B/ALUOp hold a valid operation.
- out_ready  input  1  ALU stage consumes the slot this cycle.
- A  output  WIDTH  registered operand A.
- B  output  WIDTH  registered operand B.
- ALUOp  output  3  registered opcode.

Behaviour:
- Reset: one clock is sufficient. At the next rising edge with reset=1, all 32 registers, out_valid, A, B and ALUOp become 0. This applies mid-operation too: a held slot is dropped. While reset=1, writes and captures are ignored.
- Register file writes:
  - At posedge, reg[wa] <= wd when we=1 and wa != 0.
  - reg[0] always reads 0; a write to reg[0] is silently ignored.
- Register file reads:
  - Combinational, with write-through bypass.
  - If we=1, wa != 0 and wa == rs, the read value for A is wd, not the stale reg[rs].
  - The same rule applies to rt for B.
  - rs == rt is legal; both operands get the same value.
- Operand select: A_next = rd(rs); B_next = use_imm ? imm : rd(rt); ALUOp_next = op_in.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational, with no bubble on back-to-back streaming.
  - Capture: when in_valid && in_ready && !flush, at posedge A/B/ALUOp load the *_next values and out_valid <= 1. Latency is 1 cycle from input to out_valid.
  - Consume-only: when out_ready=1 and there is no capture, out_valid <= 0. A/B/ALUOp keep their last values (don't-care).
  - Stall: when out_valid=1 and out_ready=0, A/B/ALUOp/out_valid stay constant.
  - A stalled slot holds its captured operands even if the register file writes rs/rt during the stall. Hazard resolution belongs upstream.
- Flush: at the next posedge, out_valid <= 0 and no capture occurs, even if in_valid && in_ready. Write-back still happens on that edge. in_ready is unaffected by flush.
- Simultaneous events:
  - A capture and a write-back in the same cycle happen together; the bypass supplies the new value.
  - A consume and a capture in the same cycle leave out_valid=1 with the new operands.
- Reset and flush both present: reset wins.
- No arithmetic is performed in this block. imm is passed through unmodified.

Test Plan:
1. Reset, then we=1 wa=1 wd=32'hf0001000; next cycle in_valid=1 rs=1 use_imm=1 imm=1 op_in=3'b101, out_ready=1 -> one cycle later out_valid=1, A=32'hf0001000, B=1, ALUOp=3'b101.
2. Bypass: in the same cycle, we=1 wa=2 wd=32'h12345678 and capture rs=2 rt=2 use_imm=0 -> A=B=32'h12345678 (not 0).
3. Zero register: we=1 wa=0 wd=32'hFFFFFFFF, then capture rs=0 rt=0 -> A=B=0, in both the bypass cycle and later cycles.
4. Stall: slot valid, out_ready=0 for 3 cycles while reg[1] is rewritten to 32'h5 and in_valid=1 -> in_ready=0; A stays 32'hf0001000; out_valid stays 1. Then out_ready=1 -> new capture in the same cycle, no bubble.
5. Flush: slot valid, flush=1 with in_valid=1 -> next cycle out_valid=0; reg write in that cycle still visible to a later read.
6. Mid-operation reset: slot held (out_ready=0), reset=1 for one cycle -> out_valid=0, A=B=0, ALUOp=0; reading reg[1] afterwards returns 0.
